// File: rtl/sonar_uc.sv
// sonar_uc: sequences one sonar step: measure, send eight ASCII characters,
// advance the servo, then wait a settling interval.
module sonar_uc #(
    parameter int T_ESPERA  = 100_000_000,
    parameter int T_TIMEOUT = 2_000_000,
    parameter int W_CONT    = 27
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       medida_pronto,
    input  logic       envio_pronto,
    output logic       medir,
    output logic       transmitir,
    output logic       girar,
    output logic [2:0] sel_char,
    output logic       fim_ciclo,
    output logic       timeout,
    output logic [3:0] db_estado
);
    typedef enum logic [3:0] {
        INICIAL        = 4'd0,
        PREPARA        = 4'd1,
        MEDE           = 4'd2,
        AGUARDA_MEDIDA = 4'd3,
        TRANSMITE      = 4'd4,
        AGUARDA_ENVIO  = 4'd5,
        PROXIMO_CHAR   = 4'd6,
        FIM_ENVIO      = 4'd7,
        GIRA           = 4'd8,
        ESPERA         = 4'd9
    } estado_t;

    estado_t             estado, proximo;
    logic [W_CONT-1:0]   cont;
    logic                fim_timeout, fim_espera;

    assign fim_timeout = cont == W_CONT'(T_TIMEOUT - 1);
    assign fim_espera  = cont == W_CONT'(T_ESPERA - 1);

    // Counter runs only in the two waiting states, so it is already zero on entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado   <= INICIAL;
            cont     <= '0;
            sel_char <= '0;
            timeout  <= 1'b0;
        end else begin
            estado   <= proximo;
            cont     <= (estado == AGUARDA_MEDIDA || estado == ESPERA) ? cont + 1'b1 : '0;
            sel_char <= (estado == PREPARA) ? 3'd0 :
                        (estado == PROXIMO_CHAR && sel_char != 3'd7) ? sel_char + 3'd1 : sel_char;
            timeout  <= (estado == PREPARA) ? 1'b0 :
                        (estado == AGUARDA_MEDIDA && !medida_pronto && fim_timeout) ? 1'b1 : timeout;
        end
    end

    always_comb begin
        proximo    = INICIAL;
        medir      = 1'b0;
        transmitir = 1'b0;
        girar      = 1'b0;
        fim_ciclo  = 1'b0;
        case (estado)
            INICIAL:        proximo = ligar ? PREPARA : INICIAL;
            PREPARA:        proximo = MEDE;
            MEDE: begin
                medir   = 1'b1;
                proximo = AGUARDA_MEDIDA;
            end
            AGUARDA_MEDIDA: proximo = medida_pronto ? TRANSMITE : fim_timeout ? GIRA : AGUARDA_MEDIDA;
            TRANSMITE: begin
                transmitir = 1'b1;
                proximo    = AGUARDA_ENVIO;
            end
            AGUARDA_ENVIO:  proximo = envio_pronto ? PROXIMO_CHAR : AGUARDA_ENVIO;
            PROXIMO_CHAR:   proximo = (sel_char == 3'd7) ? FIM_ENVIO : TRANSMITE;
            FIM_ENVIO: begin
                fim_ciclo = 1'b1;
                proximo   = GIRA;
            end
            GIRA: begin
                girar   = 1'b1;
                proximo = ESPERA;
            end
            ESPERA:         proximo = !fim_espera ? ESPERA : ligar ? PREPARA : INICIAL;
            default:        proximo = INICIAL;
        endcase
    end

    assign db_estado = estado;
endmodule
